darkriscv_instr_monitor: RTL and testbench

- Synthesisable run-time monitor for the darkriscv core. Sits beside the core on the instruction and data buses; does not drive the core.
- Decodes every issued instruction into an opcode class and keeps saturating per-class and per-thread retire counters.
- Raises sticky protocol-error flags, captures the instruction address of the first error, and pulses an interrupt.
- Generalises the core's static decode/assert checker into a parametrised, clearable, readable hardware block.

---
 rtl/darkriscv_instr_monitor_if.sv | 41 ++++
 rtl/darkriscv_instr_monitor.sv | 170 +++++++++++++++++
 tb/tb_darkriscv_instr_monitor.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/darkriscv_instr_monitor_if.sv
// darkriscv_instr_monitor_if
//   Groups the core-side observation signals and the monitor readout
//   signals for darkriscv_instr_monitor.
//
//   Core side (observed):  HLT, IDATA, IADDR, RD, WR, TPTR
//   Control / select:      CLR, SEL, TSEL
//   Readout:               CNT, TCNT, ERR, ERR_ADDR, IRQ
//
//   master : the environment (core plus host) driving observations and selects
//   slave  : the monitor, which produces the readout
interface darkriscv_instr_monitor_if #(
  parameter int THREADS = 1,
  parameter int CNT_W   = 16
);
  localparam int TW = (THREADS > 1) ? $clog2(THREADS) : 1;

  logic             HLT;
  logic [31:0]      IDATA;
  logic [31:0]      IADDR;
  logic             RD;
  logic             WR;
  logic [TW-1:0]    TPTR;
  logic             CLR;
  logic [3:0]       SEL;
  logic [CNT_W-1:0] CNT;
  logic [TW-1:0]    TSEL;
  logic [CNT_W-1:0] TCNT;
  logic [3:0]       ERR;
  logic [31:0]      ERR_ADDR;
  logic             IRQ;

  modport master (
    output HLT, IDATA, IADDR, RD, WR, TPTR, CLR, SEL, TSEL,
    input  CNT, TCNT, ERR, ERR_ADDR, IRQ
  );

  modport slave (
    input  HLT, IDATA, IADDR, RD, WR, TPTR, CLR, SEL, TSEL,
    output CNT, TCNT, ERR, ERR_ADDR, IRQ
  );
endinterface

// File: rtl/darkriscv_instr_monitor.sv
// darkriscv_instr_monitor
//   Passive run-time monitor for the darkriscv core. Decodes every issued
//   instruction into one of ten opcode classes, keeps saturating per-class
//   and per-thread counters, and raises sticky protocol-error flags with
//   capture of the instruction address of the first error plus a one-cycle
//   interrupt pulse.
//
//   Ports:
//     CLK  - clock, all state updates on the rising edge
//     RES  - synchronous active-high reset
//     bus  - darkriscv_instr_monitor_if.slave
//            inputs : HLT, IDATA, IADDR, RD, WR, TPTR, CLR, SEL, TSEL
//            outputs: CNT (class counter SEL), TCNT (thread counter TSEL),
//                     ERR (sticky flags), ERR_ADDR, IRQ
//
//   Error flags: [0] illegal instruction issued, [1] RD and WR together,
//                [2] HLT held longer than HLT_MAX cycles, [3] counter overflow.
module darkriscv_instr_monitor #(
  parameter int CNT_W   = 16,
  parameter int THREADS = 1,
  parameter int HLT_MAX = 15
) (
  input  logic                       CLK,
  input  logic                       RES,
  darkriscv_instr_monitor_if.slave   bus
);

  localparam int             TW      = (THREADS > 1) ? $clog2(THREADS) : 1;
  localparam int             TN      = 1 << TW;
  localparam logic [7:0]     HLT_LIM = 8'(HLT_MAX);
  localparam logic [TW:0]    THR_NUM = (TW+1)'(THREADS);
  localparam logic [3:0]     CLS_ILL = 4'd9;

  typedef enum logic {CLEAN, FAULT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cls_cnt [0:9];
  logic [CNT_W-1:0] thr_cnt [0:TN-1];
  logic [7:0]       hlt_run;
  logic [3:0]       err_q;
  logic [31:0]      err_addr_q;
  logic             irq_q;

  logic [3:0]       cls;
  logic [6:0]       opc;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic             issue;
  logic             thr_ok;
  logic             cls_full;
  logic             thr_full;
  logic             first_err;
  logic [3:0]       err_cond;
  logic [CNT_W-1:0] cnt_mux;
  logic [CNT_W-1:0] tcnt_mux;
  logic             unused_idata;

  assign opc          = bus.IDATA[6:0];
  assign f3           = bus.IDATA[14:12];
  assign f7           = bus.IDATA[31:25];
  assign unused_idata = ^{bus.IDATA[24:15], bus.IDATA[11:7]};

  assign issue    = !RES && !bus.HLT;
  // Thread pointers beyond THREADS (non power-of-two configs) are not counted.
  assign thr_ok   = ({1'b0, bus.TPTR} < THR_NUM);
  assign cls_full = (cls_cnt[cls] == {CNT_W{1'b1}});
  assign thr_full = thr_ok && (thr_cnt[bus.TPTR] == {CNT_W{1'b1}});

  // Opcode class decode; anything not recognised falls into ILLEGAL.
  always_comb begin
    cls = CLS_ILL;
    case (opc)
      7'b0110111: cls = 4'd0;
      7'b0010111: cls = 4'd1;
      7'b1101111: cls = 4'd2;
      7'b1100111: if (f3 == 3'd0) cls = 4'd3;
      7'b1100011: if (f3 != 3'd2 && f3 != 3'd3) cls = 4'd4;
      7'b0000011: if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
                      f3 == 3'd4 || f3 == 3'd5) cls = 4'd5;
      7'b0100011: if (f3 <= 3'd2) cls = 4'd6;
      7'b0010011: begin
        // Only the shift-immediates constrain funct7.
        if (f3 == 3'd1)      begin if (f7 == 7'h00) cls = 4'd7; end
        else if (f3 == 3'd5) begin if (f7 == 7'h00 || f7 == 7'h20) cls = 4'd7; end
        else                 cls = 4'd7;
      end
      7'b0110011: if (f7 == 7'h00 ||
                      (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) cls = 4'd8;
      default: cls = CLS_ILL;
    endcase
  end

  // Raw error conditions for this cycle; RES masks all of them.
  always_comb begin
    err_cond    = 4'b0000;
    err_cond[0] = issue && (cls == CLS_ILL);
    err_cond[1] = !RES && bus.RD && bus.WR;
    err_cond[2] = !RES && bus.HLT && (hlt_run == HLT_LIM);
    err_cond[3] = issue && (cls_full || thr_full);
  end

  // Error FSM next state: the CLEAN->FAULT transition is the first error,
  // which is what captures the address and fires the interrupt.
  always_comb begin
    state_nxt = state;
    first_err = 1'b0;
    if (bus.CLR) begin
      state_nxt = CLEAN;
    end else if (state == CLEAN && (|err_cond)) begin
      state_nxt = FAULT;
      first_err = 1'b1;
    end
  end

  // Error FSM state register.
  always_ff @(posedge CLK) begin
    if (RES) state <= CLEAN;
    else     state <= state_nxt;
  end

  // Sticky flags, first-error address and the one-cycle interrupt.
  always_ff @(posedge CLK) begin
    if (RES || bus.CLR) begin
      err_q      <= 4'b0000;
      err_addr_q <= 32'h0;
      irq_q      <= 1'b0;
    end else begin
      err_q <= err_q | err_cond;
      irq_q <= first_err;
      if (first_err) err_addr_q <= bus.IADDR;
    end
  end

  // Consecutive-halt counter feeding the watchdog, saturating at 255.
  always_ff @(posedge CLK) begin
    if (RES || bus.CLR) begin
      hlt_run <= 8'd0;
    end else if (bus.HLT) begin
      if (hlt_run != 8'hFF) hlt_run <= hlt_run + 8'd1;
    end else begin
      hlt_run <= 8'd0;
    end
  end

  // Class and thread counters; a full counter holds rather than wrapping.
  always_ff @(posedge CLK) begin
    if (RES || bus.CLR) begin
      for (int i = 0; i < 10; i++) cls_cnt[i] <= '0;
      for (int j = 0; j < TN; j++) thr_cnt[j] <= '0;
    end else if (issue) begin
      if (!cls_full) cls_cnt[cls] <= cls_cnt[cls] + CNT_W'(1);
      if (thr_ok && !thr_full) thr_cnt[bus.TPTR] <= thr_cnt[bus.TPTR] + CNT_W'(1);
    end
  end

  // Readout muxes; out-of-range selects read zero.
  always_comb begin
    cnt_mux  = '0;
    tcnt_mux = '0;
    if (bus.SEL <= CLS_ILL) cnt_mux = cls_cnt[bus.SEL];
    if ({1'b0, bus.TSEL} < THR_NUM) tcnt_mux = thr_cnt[bus.TSEL];
  end

  assign bus.CNT      = cnt_mux;
  assign bus.TCNT     = tcnt_mux;
  assign bus.ERR      = err_q;
  assign bus.ERR_ADDR = err_addr_q;
  assign bus.IRQ      = irq_q;

endmodule

// File: tb/tb_darkriscv_instr_monitor.sv
// tb_darkriscv_instr_monitor
//   Directed bench for darkriscv_instr_monitor configured with CNT_W=4,
//   THREADS=4, HLT_MAX=15. Inputs change 1 time unit after the rising edge
//   and outputs are sampled there too, so each stimulus step shows the
//   registered effect of the previous cycle.
module tb_darkriscv_instr_monitor;

  localparam logic [31:0] ADDI  = 32'h00100093;
  localparam logic [31:0] LW    = 32'h0000A103;
  localparam logic [31:0] ADD   = 32'h002081B3;
  localparam logic [31:0] ILL   = 32'hFFFFFFFF;
  localparam logic [31:0] LUI   = 32'h123450B7;
  localparam logic [31:0] AUIPC = 32'h00000017;

  logic CLK = 1'b0;
  logic RES = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [31:0] dec_ins [0:23] = '{
    32'h00000037, 32'h00000017, 32'h0000006F, 32'h00008067,
    32'h00009067, 32'h00000063, 32'h00002063, 32'h00003063,
    32'h00007063, 32'h00004003, 32'h00003003, 32'h00006003,
    32'h00002023, 32'h00003023, 32'h00001013, 32'h40001013,
    32'h40005013, 32'h02005013, 32'hFE002013, 32'h40000033,
    32'h40001033, 32'h02000033, 32'h00007033, 32'h00000000
  };
  logic [3:0] dec_cls [0:23] = '{
    4'd0, 4'd1, 4'd2, 4'd3,
    4'd9, 4'd4, 4'd9, 4'd9,
    4'd4, 4'd5, 4'd9, 4'd9,
    4'd6, 4'd9, 4'd7, 4'd9,
    4'd7, 4'd9, 4'd7, 4'd8,
    4'd9, 4'd9, 4'd8, 4'd9
  };

  darkriscv_instr_monitor_if #(.THREADS(4), .CNT_W(4)) bus ();

  darkriscv_instr_monitor #(.CNT_W(4), .THREADS(4), .HLT_MAX(15)) dut (
    .CLK (CLK),
    .RES (RES),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle of inputs and advance to just after the next rising edge.
  task automatic applyStimulus(input logic hlt, input logic [31:0] idata,
                               input logic [31:0] iaddr, input logic rd,
                               input logic wr, input logic [1:0] tptr,
                               input logic clr);
    bus.HLT   = hlt;
    bus.IDATA = idata;
    bus.IADDR = iaddr;
    bus.RD    = rd;
    bus.WR    = wr;
    bus.TPTR  = tptr;
    bus.CLR   = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RES = 1'b1;
    applyStimulus(1'b0, ADDI, 32'h10, 1'b1, 1'b1, 2'd0, 1'b0);
    applyStimulus(1'b0, ILL,  32'h14, 1'b1, 1'b1, 2'd0, 1'b0);
    RES = 1'b0; bus.HLT = 1'b1; bus.RD = 1'b0; bus.WR = 1'b0;
    bus.SEL = 4'd7; bus.TSEL = 2'd0; #1;
    n_cmp++; if (bus.CNT !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d want 0", bus.CNT); end
    n_cmp++; if (bus.TCNT !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_tcnt: got %0d want 0", bus.TCNT); end
    n_cmp++; if (bus.ERR !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_err: got %b want 0000", bus.ERR); end
    n_cmp++; if (bus.ERR_ADDR !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_addr: got %h want 0", bus.ERR_ADDR); end
    n_cmp++; if (bus.IRQ !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_irq: got %b want 0", bus.IRQ); end
  endtask

  task automatic test_mix();
    logic irq_seen;
    irq_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, ADDI, 32'h20 + 32'(4*i), 1'b0, 1'b0, 2'd0, 1'b0);
      irq_seen = irq_seen | bus.IRQ;
    end
    applyStimulus(1'b0, LW, 32'h2C, 1'b0, 1'b0, 2'd0, 1'b0);
    irq_seen = irq_seen | bus.IRQ;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, ADD, 32'h30 + 32'(4*i), 1'b0, 1'b0, 2'd0, 1'b0);
      irq_seen = irq_seen | bus.IRQ;
    end
    bus.HLT = 1'b1;
    bus.SEL = 4'd7; bus.TSEL = 2'd0; #1;
    n_cmp++; if (bus.CNT !== 4'd3) begin n_fail++; $display("[TB] FAIL mix_mcc: got %0d want 3", bus.CNT); end
    n_cmp++; if (bus.TCNT !== 4'd6) begin n_fail++; $display("[TB] FAIL mix_thread0: got %0d want 6", bus.TCNT); end
    bus.SEL = 4'd5; #1;
    n_cmp++; if (bus.CNT !== 4'd1) begin n_fail++; $display("[TB] FAIL mix_lcc: got %0d want 1", bus.CNT); end
    bus.SEL = 4'd8; #1;
    n_cmp++; if (bus.CNT !== 4'd2) begin n_fail++; $display("[TB] FAIL mix_rcc: got %0d want 2", bus.CNT); end
    n_cmp++; if (bus.ERR !== 4'b0000) begin n_fail++; $display("[TB] FAIL mix_err: got %b want 0000", bus.ERR); end
    n_cmp++; if (irq_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL mix_irq: got %b want 0", irq_seen); end
  endtask

  task automatic test_illegal();
    applyStimulus(1'b1, ADDI, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1);
    applyStimulus(1'b0, ILL, 32'h100, 1'b0, 1'b0, 2'd0, 1'b0);
    bus.HLT = 1'b1;
    n_cmp++; if (bus.ERR !== 4'b0001) begin n_fail++; $display("[TB] FAIL ill_err: got %b want 0001", bus.ERR); end
    n_cmp++; if (bus.ERR_ADDR !== 32'h100) begin n_fail++; $display("[TB] FAIL ill_addr: got %h want 00000100", bus.ERR_ADDR); end
    n_cmp++; if (bus.IRQ !== 1'b1) begin n_fail++; $display("[TB] FAIL ill_irq: got %b want 1", bus.IRQ); end
    bus.SEL = 4'd9; #1;
    n_cmp++; if (bus.CNT !== 4'd1) begin n_fail++; $display("[TB] FAIL ill_cnt: got %0d want 1", bus.CNT); end
    bus.SEL = 4'd10; #1;
    n_cmp++; if (bus.CNT !== 4'd0) begin n_fail++; $display("[TB] FAIL sel10: got %0d want 0", bus.CNT); end
    bus.SEL = 4'd15; #1;
    n_cmp++; if (bus.CNT !== 4'd0) begin n_fail++; $display("[TB] FAIL sel15: got %0d want 0", bus.CNT); end
    applyStimulus(1'b1, ILL, 32'h200, 1'b1, 1'b1, 2'd0, 1'b0);
    n_cmp++; if (bus.ERR !== 4'b0011) begin n_fail++; $display("[TB] FAIL rdwr_err: got %b want 0011", bus.ERR); end
    n_cmp++; if (bus.ERR_ADDR !== 32'h100) begin n_fail++; $display("[TB] FAIL rdwr_addr: got %h want 00000100", bus.ERR_ADDR); end
    n_cmp++; if (bus.IRQ !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_width: got %b want 0", bus.IRQ); end
    applyStimulus(1'b1, ILL, 32'h200, 1'b0, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (bus.IRQ !== 1'b0) begin n_fail++; $display("[TB] FAIL rdwr_noirq: got %b want 0", bus.IRQ); end
  endtask

  task automatic test_halt();
    applyStimulus(1'b0, ADDI, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, ILL, 32'h80, 1'b0, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (bus.ERR !== 4'b0000) begin n_fail++; $display("[TB] FAIL halt15_err: got %b want 0000", bus.ERR); end
    bus.SEL = 4'd9; #1;
    n_cmp++; if (bus.CNT !== 4'd0) begin n_fail++; $display("[TB] FAIL halt_nocount: got %0d want 0", bus.CNT); end
    applyStimulus(1'b0, ADDI, 32'h84, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, ILL, 32'h88, 1'b0, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b0, ADDI, 32'h8C, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, ILL, 32'h90, 1'b0, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (bus.ERR !== 4'b0000) begin n_fail++; $display("[TB] FAIL halt_gap_err: got %b want 0000", bus.ERR); end
    bus.SEL = 4'd7; bus.TSEL = 2'd0; #1;
    n_cmp++; if (bus.CNT !== 4'd2) begin n_fail++; $display("[TB] FAIL halt_mcc: got %0d want 2", bus.CNT); end
    n_cmp++; if (bus.TCNT !== 4'd2) begin n_fail++; $display("[TB] FAIL halt_tcnt: got %0d want 2", bus.TCNT); end
    applyStimulus(1'b0, ADDI, 32'h94, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, ILL, 32'h300, 1'b0, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (bus.ERR !== 4'b0000) begin n_fail++; $display("[TB] FAIL halt_pre16: got %b want 0000", bus.ERR); end
    applyStimulus(1'b1, ILL, 32'h300, 1'b0, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (bus.ERR !== 4'b0100) begin n_fail++; $display("[TB] FAIL halt16_err: got %b want 0100", bus.ERR); end
    n_cmp++; if (bus.IRQ !== 1'b1) begin n_fail++; $display("[TB] FAIL halt16_irq: got %b want 1", bus.IRQ); end
    n_cmp++; if (bus.ERR_ADDR !== 32'h300) begin n_fail++; $display("[TB] FAIL halt16_addr: got %h want 00000300", bus.ERR_ADDR); end
    applyStimulus(1'b1, ILL, 32'h300, 1'b0, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (bus.IRQ !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_irq_drop: got %b want 0", bus.IRQ); end
  endtask

  task automatic test_saturate();
    applyStimulus(1'b1, ADDI, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, LUI, 32'h1000 + 32'(4*i), 1'b0, 1'b0, 2'(i), 1'b0);
      if (i == 14) begin
        n_cmp++; if (bus.ERR !== 4'b0000) begin n_fail++; $display("[TB] FAIL sat15_err: got %b want 0000", bus.ERR); end
        bus.SEL = 4'd0; #1;
        n_cmp++; if (bus.CNT !== 4'd15) begin n_fail++; $display("[TB] FAIL sat15_cnt: got %0d want 15", bus.CNT); end
      end
    end
    bus.HLT = 1'b1;
    n_cmp++; if (bus.ERR !== 4'b1000) begin n_fail++; $display("[TB] FAIL sat16_err: got %b want 1000", bus.ERR); end
    n_cmp++; if (bus.IRQ !== 1'b1) begin n_fail++; $display("[TB] FAIL sat16_irq: got %b want 1", bus.IRQ); end
    n_cmp++; if (bus.ERR_ADDR !== 32'h103C) begin n_fail++; $display("[TB] FAIL sat16_addr: got %h want 0000103c", bus.ERR_ADDR); end
    bus.SEL = 4'd0; #1;
    n_cmp++; if (bus.CNT !== 4'd15) begin n_fail++; $display("[TB] FAIL sat_hold: got %0d want 15", bus.CNT); end
    for (int t = 0; t < 4; t++) begin
      bus.TSEL = 2'(t); #1;
      n_cmp++; if (bus.TCNT !== 4'd4) begin n_fail++; $display("[TB] FAIL sat_thr%0d: got %0d want 4", t, bus.TCNT); end
    end
    applyStimulus(1'b1, ADDI, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, (i % 2 == 1) ? AUIPC : LUI, 32'h2000 + 32'(4*i), 1'b0, 1'b0, 2'd2, 1'b0);
      if (i == 14) begin
        n_cmp++; if (bus.ERR !== 4'b0000) begin n_fail++; $display("[TB] FAIL tsat15_err: got %b want 0000", bus.ERR); end
      end
    end
    bus.HLT = 1'b1;
    n_cmp++; if (bus.ERR !== 4'b1000) begin n_fail++; $display("[TB] FAIL tsat16_err: got %b want 1000", bus.ERR); end
    bus.TSEL = 2'd2; bus.SEL = 4'd1; #1;
    n_cmp++; if (bus.TCNT !== 4'd15) begin n_fail++; $display("[TB] FAIL tsat_tcnt: got %0d want 15", bus.TCNT); end
    n_cmp++; if (bus.CNT !== 4'd8) begin n_fail++; $display("[TB] FAIL tsat_auipc: got %0d want 8", bus.CNT); end
    bus.SEL = 4'd0; #1;
    n_cmp++; if (bus.CNT !== 4'd8) begin n_fail++; $display("[TB] FAIL tsat_lui: got %0d want 8", bus.CNT); end
  endtask

  task automatic test_clr();
    applyStimulus(1'b1, ADDI, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1);
    applyStimulus(1'b0, ILL, 32'h400, 1'b1, 1'b1, 2'd0, 1'b1);
    n_cmp++; if (bus.ERR !== 4'b0000) begin n_fail++; $display("[TB] FAIL clr_same_err: got %b want 0000", bus.ERR); end
    n_cmp++; if (bus.IRQ !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_same_irq: got %b want 0", bus.IRQ); end
    applyStimulus(1'b0, ILL, 32'h500, 1'b0, 1'b0, 2'd0, 1'b0);
    bus.HLT = 1'b1;
    n_cmp++; if (bus.ERR !== 4'b0001) begin n_fail++; $display("[TB] FAIL clr_next_err: got %b want 0001", bus.ERR); end
    n_cmp++; if (bus.IRQ !== 1'b1) begin n_fail++; $display("[TB] FAIL clr_next_irq: got %b want 1", bus.IRQ); end
    n_cmp++; if (bus.ERR_ADDR !== 32'h500) begin n_fail++; $display("[TB] FAIL clr_next_addr: got %h want 00000500", bus.ERR_ADDR); end
    bus.SEL = 4'd9; bus.TSEL = 2'd0; #1;
    n_cmp++; if (bus.CNT !== 4'd1) begin n_fail++; $display("[TB] FAIL clr_cnt: got %0d want 1", bus.CNT); end
    n_cmp++; if (bus.TCNT !== 4'd1) begin n_fail++; $display("[TB] FAIL clr_tcnt: got %0d want 1", bus.TCNT); end
    applyStimulus(1'b1, ADDI, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1);
    n_cmp++; if (bus.ERR !== 4'b0000) begin n_fail++; $display("[TB] FAIL clr_fault_err: got %b want 0000", bus.ERR); end
    n_cmp++; if (bus.ERR_ADDR !== 32'h0) begin n_fail++; $display("[TB] FAIL clr_fault_addr: got %h want 0", bus.ERR_ADDR); end
  endtask

  task automatic test_decode();
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b1, ADDI, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1);
      applyStimulus(1'b0, dec_ins[i], 32'h40, 1'b0, 1'b0, 2'd0, 1'b0);
      bus.HLT = 1'b1;
      bus.SEL = dec_cls[i]; #1;
      n_cmp++; if (bus.CNT !== 4'd1) begin n_fail++; $display("[TB] FAIL decode_%h: class %0d count got %0d want 1", dec_ins[i], dec_cls[i], bus.CNT); end
      n_cmp++; if (bus.ERR !== ((dec_cls[i] == 4'd9) ? 4'b0001 : 4'b0000)) begin n_fail++; $display("[TB] FAIL decode_err_%h: got %b want %b", dec_ins[i], bus.ERR, (dec_cls[i] == 4'd9) ? 4'b0001 : 4'b0000); end
    end
  endtask

  task automatic test_threads();
    applyStimulus(1'b1, ADDI, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1);
    applyStimulus(1'b0, ADDI, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b0, ADDI, 32'h4, 1'b0, 1'b0, 2'd1, 1'b0);
    applyStimulus(1'b0, ADDI, 32'h8, 1'b0, 1'b0, 2'd3, 1'b0);
    applyStimulus(1'b0, ADDI, 32'hC, 1'b0, 1'b0, 2'd3, 1'b0);
    bus.HLT = 1'b1;
    bus.TSEL = 2'd0; #1;
    n_cmp++; if (bus.TCNT !== 4'd1) begin n_fail++; $display("[TB] FAIL thr0: got %0d want 1", bus.TCNT); end
    bus.TSEL = 2'd1; #1;
    n_cmp++; if (bus.TCNT !== 4'd1) begin n_fail++; $display("[TB] FAIL thr1: got %0d want 1", bus.TCNT); end
    bus.TSEL = 2'd2; #1;
    n_cmp++; if (bus.TCNT !== 4'd0) begin n_fail++; $display("[TB] FAIL thr2: got %0d want 0", bus.TCNT); end
    bus.TSEL = 2'd3; #1;
    n_cmp++; if (bus.TCNT !== 4'd2) begin n_fail++; $display("[TB] FAIL thr3: got %0d want 2", bus.TCNT); end
    applyStimulus(1'b0, ILL, 32'h600, 1'b0, 1'b0, 2'd1, 1'b0);
    n_cmp++; if (bus.IRQ !== 1'b1) begin n_fail++; $display("[TB] FAIL thr_ill_irq: got %b want 1", bus.IRQ); end
    RES = 1'b1;
    applyStimulus(1'b0, ILL, 32'h700, 1'b1, 1'b1, 2'd2, 1'b0);
    n_cmp++; if (bus.IRQ !== 1'b0) begin n_fail++; $display("[TB] FAIL res_irq: got %b want 0", bus.IRQ); end
    n_cmp++; if (bus.ERR !== 4'b0000) begin n_fail++; $display("[TB] FAIL res_err: got %b want 0000", bus.ERR); end
    n_cmp++; if (bus.ERR_ADDR !== 32'h0) begin n_fail++; $display("[TB] FAIL res_addr: got %h want 0", bus.ERR_ADDR); end
    RES = 1'b0; bus.HLT = 1'b1; bus.RD = 1'b0; bus.WR = 1'b0;
    bus.SEL = 4'd7; bus.TSEL = 2'd3; #1;
    n_cmp++; if (bus.CNT !== 4'd0) begin n_fail++; $display("[TB] FAIL res_cnt: got %0d want 0", bus.CNT); end
    n_cmp++; if (bus.TCNT !== 4'd0) begin n_fail++; $display("[TB] FAIL res_tcnt: got %0d want 0", bus.TCNT); end
  endtask

  initial begin
    bus.HLT = 1'b1; bus.IDATA = ADDI; bus.IADDR = 32'h0;
    bus.RD = 1'b0; bus.WR = 1'b0; bus.TPTR = 2'd0; bus.CLR = 1'b0;
    bus.SEL = 4'd0; bus.TSEL = 2'd0;
    $display("[TB] darkriscv_instr_monitor directed tests");
    test_reset();
    test_mix();
    test_illegal();
    test_halt();
    test_saturate();
    test_clr();
    test_decode();
    test_threads();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
